uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised RS-232 UART receiver, successor to the fixed 8-bit receiver.
//  Oversamples Rx, finds the centre of each bit, and supports 5-9 data bits,
//  optional even/odd parity and 1 or 2 stop bits. Flags framing, parity and
//  overrun errors. Delivers each frame through a one-entry Valid/Ready output
//  register to the Nios-side bus logic.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD        9600      line rate, bit/s
//  OVERSAMPLE  16        ticks per bit; must be even, >=8
//  DATA_BITS   8         data bits per frame, 5..9, sent LSB first
//  PARITY      0         0 = none, 1 = even, 2 = odd
//  STOP_BITS   1         1 or 2
//  TICK_DIV    (CLK_FREQ+BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), derived; 326 at defaults
// PORTS
//  Clock         in   1          system clock, rising edge
//  Reset         in   1          asynchronous, active-low; all state cleared while 0
//  Rx            in   1          asynchronous serial line; idles high
//  Data          out  DATA_BITS  received word; meaningful only while Valid=1
//  Valid         out  1          Data, FramingError and ParityError are held for the consumer
//  Ready         in   1          consumer accepts the frame when Valid&Ready at a Clock edge
//  FramingError  out  1          a stop bit of the held frame was sampled 0
//  ParityError   out  1          parity mismatch on the held frame; always 0 when PARITY=0
//  Overrun       out  1          sticky: a frame was lost because Valid was still pending
//  Busy          out  1          1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: Data=0, Valid=0, FramingError=0, ParityError=0, Overrun=0,
//   Busy=0, FSM=IDLE, disarmed, both synchroniser flops=1.
//  Rx passes through a 2-flop synchroniser (rxs); all decisions use rxs.
//  Bit period is BT = TICK_DIV*OVERSAMPLE clocks. The phase counter is held at 0 in IDLE.
//  FSM states:
//   IDLE:   arms once rxs=1 has been seen, so reset never starts mid-frame.
//           If armed and rxs=0, restart the phase counter and go to START.
//   START:  at BT/2 clocks, sample rxs. If 1, it was a glitch: go to IDLE, no flags.
//           If 0, go to DATA with bit index 0.
//   DATA:   sample every BT clocks at the bit centre; shift right so bit 0 arrives first.
//           After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
//   PARITY: sample one bit. Even: error if XOR(data,p)=1. Odd: error if XOR(data,p)=0.
//   STOP:   sample STOP_BITS bits; any 0 sets the frame framing flag.
//           At the centre of the last stop bit, complete the frame and go to IDLE.
//           This permits back-to-back frames with no idle gap.
//   A frame with a framing error returns to IDLE disarmed, so a break
//   (line held low) yields exactly one frame.
//  Frame completion: Valid rises on the clock after the last stop sample.
//   Data, FramingError and ParityError are loaded together in that same cycle.
//  Handshake: Valid, Data and the error flags stay stable until Valid&Ready.
//   Then Valid=0 on the next clock unless a new frame completes in that same cycle.
//  Frame completes and Valid&Ready in the same cycle: the new frame is loaded,
//   Valid stays 1, no overrun.
//  Frame completes with Valid=1 and Ready=0: the new frame is discarded,
//   held data is unchanged, Overrun=1.
//  Overrun clears on the next Valid&Ready handshake.
//  Reset asserted mid-frame: immediate return to reset values. After release,
//   reception waits for rxs=1 before re-arming.
// TESTING (defaults unless stated; BT=5216 clocks)
//  1. Send 8N1 0xA5, Ready=0 -> Data=0xA5, Valid=1, no errors, held for 3*BT;
//     Ready pulse -> Valid=0 next clock.
//  2. Rx low 1000 clocks then high -> no Valid; Busy 1 then 0 after START sample.
//  3. PARITY=1: send 0x03 with parity bit 1 -> Data=0x03, ParityError=1;
//     with parity bit 0 -> ParityError=0.
//  4. Send 0x55 with stop bit 0, then hold Rx low for 20*BT -> exactly one Valid:
//     Data=0x55, FramingError=1. Next frame after Rx returns high is received normally.
//  5. Send 0x11 then 0x22 back-to-back, Ready=0 -> Data=0x11, Overrun=1;
//     Ready pulse -> Overrun=0.
//  6. Assert Reset during data bit 4 of a frame -> all outputs 0, Valid never rises;
//     next frame 0x5A (DATA_BITS=7, STOP_BITS=2 build) -> Data=0x5A.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits,
// delivering each frame through a one-entry Valid/Ready holding register.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Data,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 FramingError,
    output logic                 ParityError,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int TICK_DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state, state_next;
    logic                   rx_meta, rxs;
    logic                   armed;
    logic [DIV_W-1:0]       div_cnt;
    logic [OS_W-1:0]        os_cnt;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_err;
    logic                   frm_err;

    logic                   tick;
    logic                   sample;
    logic                   complete;
    logic                   frame_fe;

    assign tick     = (div_cnt == DIV_LAST);
    assign frame_fe = frm_err | ~rxs;
    assign Busy     = (state != S_IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rxs) state_next = S_START;
            end
            S_START: begin
                if (tick && os_cnt == OS_HALF) begin
                    sample     = 1'b1;
                    state_next = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && os_cnt == OS_LAST) begin
                    sample = 1'b1;
                    if (bit_idx == BIT_LAST) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick && os_cnt == OS_LAST) begin
                    sample     = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && os_cnt == OS_LAST) begin
                    sample = 1'b1;
                    if (stop_idx == STOP_LAST) begin
                        complete   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Clock divider and oversample counter; both parked at zero while idle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= sample ? '0 : os_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            armed    <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rxs) armed <= 1'b1;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_err  <= 1'b0;
                    frm_err  <= 1'b0;
                end
                S_DATA: begin
                    if (sample) begin
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (sample) par_err <= (^shift) ^ rxs ^ ODD_PAR;
                end
                S_STOP: begin
                    if (sample) begin
                        frm_err  <= frame_fe;
                        stop_idx <= 1'b1;
                        // A bad stop bit means the line may be in break; wait for it to rise.
                        if (complete && frame_fe) armed <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding register: Valid/Data/flags stay put until Valid&Ready at a Clock edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Data         <= '0;
            Valid        <= 1'b0;
            FramingError <= 1'b0;
            ParityError  <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            if (Valid && Ready) Overrun <= 1'b0;
            if (complete) begin
                if (!Valid || Ready) begin
                    Data         <= shift;
                    Valid        <= 1'b1;
                    FramingError <= frame_fe;
                    ParityError  <= par_err;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Valid && Ready) begin
                Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three builds (8N1, 8E1, 7N2) on a short bit period.
module tb_uart_rx_param;

    localparam int BT = 32;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_b, rx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic       fe_a, fe_b, fe_c;
    logic       pe_a, pe_b, pe_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic       busy_a, busy_b, busy_c;

    int checks_total;
    int checks_passed;
    int rises_a;
    logic valid_a_q;

    uart_rx_param #(.CLK_FREQ(32000), .BAUD(1000), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .Clock(clk), .Reset(rst_n), .Rx(rx_a), .Data(data_a), .Valid(valid_a),
        .Ready(rdy_a), .FramingError(fe_a), .ParityError(pe_a), .Overrun(ovr_a),
        .Busy(busy_a));

    uart_rx_param #(.CLK_FREQ(32000), .BAUD(1000), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_b (
        .Clock(clk), .Reset(rst_n), .Rx(rx_b), .Data(data_b), .Valid(valid_b),
        .Ready(rdy_b), .FramingError(fe_b), .ParityError(pe_b), .Overrun(ovr_b),
        .Busy(busy_b));

    uart_rx_param #(.CLK_FREQ(32000), .BAUD(1000), .OVERSAMPLE(8),
                    .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_c (
        .Clock(clk), .Reset(rst_n), .Rx(rx_c), .Data(data_c), .Valid(valid_c),
        .Ready(rdy_c), .FramingError(fe_c), .ParityError(pe_c), .Overrun(ovr_c),
        .Busy(busy_c));

    // Clock and Valid-rise monitor for the 8N1 build
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_a && !valid_a_q) rises_a = rises_a + 1;
        valid_a_q = valid_a;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total = checks_total + 1;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else             checks_passed = checks_passed + 1;
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_bits(input int which, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(which, v[i]);
            repeat (BT) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                              input bit par_en, input logic par_bit,
                              input int nstop, input logic stop_val);
        logic [15:0] v;
        int          n;
        v    = '0;
        v[0] = 1'b0;
        n    = 1;
        for (int i = 0; i < nbits; i++) begin
            v[n] = d[i];
            n++;
        end
        if (par_en) begin
            v[n] = par_bit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            v[n] = stop_val;
            n++;
        end
        send_bits(which, v, n);
    endtask

    task automatic pulse_ready(input int which);
        case (which)
            0:       rdy_a = 1'b1;
            1:       rdy_b = 1'b1;
            default: rdy_c = 1'b1;
        endcase
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        rdy_c = 1'b0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rises_a       = 0;
        valid_a_q     = 1'b0;
        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        repeat (4) @(negedge clk);

        check_eq("reset_data",    data_a,  0);
        check_eq("reset_valid",   valid_a, 0);
        check_eq("reset_fe",      fe_a,    0);
        check_eq("reset_pe",      pe_a,    0);
        check_eq("reset_overrun", ovr_a,   0);
        check_eq("reset_busy",    busy_a,  0);

        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // 8N1 0xA5, held while Ready stays low
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        check_eq("t1_valid", valid_a, 1);
        check_eq("t1_data",  data_a,  8'hA5);
        check_eq("t1_fe",    fe_a,    0);
        check_eq("t1_pe",    pe_a,    0);
        repeat (3 * BT) @(negedge clk);
        check_eq("t1_hold_valid", valid_a, 1);
        check_eq("t1_hold_data",  data_a,  8'hA5);
        pulse_ready(0);
        check_eq("t1_valid_after_ready", valid_a, 0);

        // Short low glitch: START entered then abandoned, no frame
        rx_a = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t2_busy_in_start", busy_a, 1);
        repeat (2) @(negedge clk);
        rx_a = 1'b1;
        repeat (BT) @(negedge clk);
        check_eq("t2_busy_after", busy_a, 0);
        check_eq("t2_no_valid",   valid_a, 0);

        // Even parity: 0x03 has even weight, so parity bit 1 is an error
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
        check_eq("t3a_valid", valid_b, 1);
        check_eq("t3a_data",  data_b,  8'h03);
        check_eq("t3a_pe",    pe_b,    1);
        check_eq("t3a_fe",    fe_b,    0);
        pulse_ready(1);
        check_eq("t3a_valid_after_ready", valid_b, 0);
        repeat (BT) @(negedge clk);
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
        check_eq("t3b_valid", valid_b, 1);
        check_eq("t3b_data",  data_b,  8'h03);
        check_eq("t3b_pe",    pe_b,    0);
        pulse_ready(1);

        // Bad stop bit followed by a long break yields exactly one frame
        repeat (BT) @(negedge clk);
        rises_a = 0;
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
        repeat (20 * BT) @(negedge clk);
        check_eq("t4_one_frame", rises_a, 1);
        check_eq("t4_data",      data_a,  8'h55);
        check_eq("t4_fe",        fe_a,    1);
        pulse_ready(0);
        repeat (2 * BT) @(negedge clk);
        check_eq("t4_no_more_valid", valid_a, 0);
        rx_a = 1'b1;
        repeat (2 * BT) @(negedge clk);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        check_eq("t4_next_data",  data_a,  8'h3C);
        check_eq("t4_next_fe",    fe_a,    0);
        check_eq("t4_frame_count", rises_a, 2);
        pulse_ready(0);
        repeat (BT) @(negedge clk);

        // Back-to-back frames with Ready low: second one lost
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        check_eq("t5_data",    data_a,  8'h11);
        check_eq("t5_overrun", ovr_a,   1);
        check_eq("t5_valid",   valid_a, 1);
        pulse_ready(0);
        check_eq("t5_overrun_clear", ovr_a,   0);
        check_eq("t5_valid_clear",   valid_a, 0);

        // Reset during data bit 4 of a 7N2 frame: start, bits 0..3 of 0x2B, then half of bit 4
        repeat (BT) @(negedge clk);
        send_bits(2, 16'b0_1011_0, 5);
        rx_c = 1'b0;
        repeat (BT / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_valid", valid_c, 0);
        check_eq("t6_rst_busy",  busy_c,  0);
        check_eq("t6_rst_data",  data_c,  0);
        check_eq("t6_rst_flags", {fe_c, pe_c, ovr_c}, 0);
        repeat (3) @(negedge clk);
        rx_c = 1'b1;
        rst_n = 1'b1;
        repeat (2 * BT) @(negedge clk);
        check_eq("t6_no_valid", valid_c, 0);
        send_frame(2, 9'h05A, 7, 1'b0, 1'b0, 2, 1'b1);
        check_eq("t6_valid", valid_c, 1);
        check_eq("t6_data",  data_c,  7'h5A);
        check_eq("t6_fe",    fe_c,    0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
